chess_clock_core: RTL and testbench

Parametrised N-player chess-clock timing core. Keeps one mm:ss BCD countdown per player and passes the turn on SELECT edges. Adds a Fischer increment, flag detection and runtime preset loading. It sits between the 1 Hz prescaler (CE) and the 7-segment multiplexer, which consumes time_bcd.

---
 rtl/chess_clock_pkg.sv | 28 ++
 rtl/bcd_mmss_unit.sv | 65 ++++++
 rtl/chess_clock_core.sv | 147 ++++++++++++++
 tb/tb_chess_clock_core.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/chess_clock_pkg.sv
// Shared types and BCD helpers for the chess clock core.
// Times are packed mm:ss BCD words {m10,m1,s10,s1}.
package chess_clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    FLAGGED = 2'd3
  } state_t;

  localparam logic [15:0] BCD_MAX  = 16'h9959;
  localparam logic [15:0] BCD_ZERO = 16'h0000;

  function automatic logic [7:0] bcd2_to_bin(input logic [7:0] b);
    return 8'(b[7:4]) * 8'd10 + 8'(b[3:0]);
  endfunction

  // Only meaningful for values 0..99.
  function automatic logic [7:0] bin_to_bcd2(input logic [7:0] v);
    logic [7:0] tens;
    logic [7:0] ones;
    tens = v / 8'd10;
    ones = v - tens * 8'd10;
    return {tens[3:0], ones[3:0]};
  endfunction

endpackage

// File: rtl/bcd_mmss_unit.sv
// Combinational mm:ss arithmetic for the running player.
// Decrements by one second, then optionally adds a saturating increment.
module bcd_mmss_unit
  import chess_clock_pkg::*;
(
  input  logic [15:0] time_in,
  input  logic        dec_en,
  input  logic [7:0]  inc,
  output logic [15:0] dec_out,
  output logic        dec_zero,
  output logic [15:0] add_out
);

  logic [3:0]  m10, m1, s10, s1;
  logic [15:0] add_base;
  logic [7:0]  sec_sum;
  logic [7:0]  min_sum;

  assign m10 = time_in[15:12];
  assign m1  = time_in[11:8];
  assign s10 = time_in[7:4];
  assign s1  = time_in[3:0];

  // A time already at zero stays at zero so the caller can flag it directly.
  always_comb begin
    dec_out = time_in;
    if (time_in == BCD_ZERO) begin
      dec_out = BCD_ZERO;
    end else if (s1 != 4'd0) begin
      dec_out[3:0] = s1 - 4'd1;
    end else begin
      dec_out[3:0] = 4'd9;
      if (s10 != 4'd0) begin
        dec_out[7:4] = s10 - 4'd1;
      end else begin
        dec_out[7:4] = 4'd5;
        if (m1 != 4'd0) begin
          dec_out[11:8] = m1 - 4'd1;
        end else begin
          dec_out[11:8]  = 4'd9;
          dec_out[15:12] = m10 - 4'd1;
        end
      end
    end
  end

  assign dec_zero = (dec_out == BCD_ZERO);

  // The increment builds on the decremented value when both happen together.
  always_comb begin
    add_base = dec_en ? dec_out : time_in;
    sec_sum  = bcd2_to_bin(add_base[7:0]) + bcd2_to_bin(inc);
    min_sum  = bcd2_to_bin(add_base[15:8]);
    if (sec_sum >= 8'd60) begin
      sec_sum = sec_sum - 8'd60;
      min_sum = min_sum + 8'd1;
    end
    if (min_sum > 8'd99 || sec_sum > 8'd59) begin
      add_out = BCD_MAX;
    end else begin
      add_out = {bin_to_bcd2(min_sum), bin_to_bcd2(sec_sum)};
    end
  end

endmodule

// File: rtl/chess_clock_core.sv
// N-player chess clock: per-player mm:ss countdown, turn passing on SELECT
// rising edges, Fischer increment, flag detection and runtime preset load.
module chess_clock_core
  import chess_clock_pkg::*;
#(
  parameter int          PLAYERS  = 2,
  parameter int          PW       = 1,
  parameter logic [15:0] INIT_BCD = 16'h0500,
  parameter bit          INC_EN   = 1'b1
) (
  input  logic                   CLK,
  input  logic                   CLR,
  input  logic                   CE,
  input  logic                   SELECT,
  input  logic                   STOP,
  input  logic                   Set_Impulse,
  input  logic [15:0]            SET_BCD,
  input  logic [7:0]             INC_BCD,
  output logic [16*PLAYERS-1:0]  time_bcd,
  output logic [PW-1:0]          active,
  output logic [PLAYERS-1:0]     flag,
  output logic                   running
);

  state_t             state;
  logic               sel_q;
  logic               sel_edge;
  logic [15:0]        times [PLAYERS];
  logic [15:0]        cur_time;
  logic [PLAYERS-1:0] act_onehot;
  logic [PW-1:0]      next_active;
  logic [15:0]        dec_out;
  logic               dec_zero;
  logic [15:0]        add_out;
  logic [15:0]        upd_val;

  assign sel_edge = SELECT & ~sel_q;

  // Select the running player's time without indexing past PLAYERS.
  always_comb begin
    cur_time   = BCD_ZERO;
    act_onehot = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      if (active == PW'(p)) begin
        cur_time      = times[p];
        act_onehot[p] = 1'b1;
      end
    end
  end

  always_comb begin
    if (active == PW'(PLAYERS - 1)) next_active = '0;
    else                            next_active = active + PW'(1);
  end

  always_comb begin
    time_bcd = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      time_bcd[16*p +: 16] = times[p];
    end
  end

  bcd_mmss_unit u_bcd (
    .time_in  (cur_time),
    .dec_en   (CE),
    .inc      (INC_BCD),
    .dec_out  (dec_out),
    .dec_zero (dec_zero),
    .add_out  (add_out)
  );

  always_comb begin
    upd_val = cur_time;
    if (CE)                upd_val = dec_out;
    if (sel_edge && INC_EN) upd_val = add_out;
  end

  // Reloading to IDLE also returns active to player 0, matching reset.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state   <= IDLE;
      sel_q   <= 1'b0;
      active  <= '0;
      flag    <= '0;
      running <= 1'b0;
      for (int p = 0; p < PLAYERS; p++) times[p] <= INIT_BCD;
    end else begin
      sel_q <= SELECT;
      case (state)
        IDLE: begin
          if (Set_Impulse) begin
            for (int p = 0; p < PLAYERS; p++) times[p] <= SET_BCD;
          end
          if (sel_edge) begin
            state   <= RUN;
            active  <= '0;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (STOP) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (CE && dec_zero) begin
            for (int p = 0; p < PLAYERS; p++) begin
              if (act_onehot[p]) times[p] <= dec_out;
            end
            flag    <= flag | act_onehot;
            state   <= FLAGGED;
            running <= 1'b0;
          end else if (CE || sel_edge) begin
            for (int p = 0; p < PLAYERS; p++) begin
              if (act_onehot[p]) times[p] <= upd_val;
            end
            if (sel_edge) active <= next_active;
          end
        end
        PAUSE: begin
          if (Set_Impulse) begin
            for (int p = 0; p < PLAYERS; p++) times[p] <= SET_BCD;
            flag    <= '0;
            active  <= '0;
            state   <= IDLE;
            running <= 1'b0;
          end else if (!STOP) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        FLAGGED: begin
          if (Set_Impulse) begin
            for (int p = 0; p < PLAYERS; p++) times[p] <= SET_BCD;
            flag    <= '0;
            active  <= '0;
            state   <= IDLE;
            running <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chess_clock_core.sv
// Scoreboard bench for chess_clock_core: a 2-player and a 3-player instance,
// each exercised in turn while the other is held in reset.
module tb_chess_clock_core;

  logic        clk = 1'b0;
  logic        clr2, clr3;
  logic        sel, ce, stop, setp;
  logic [15:0] setv;
  logic [7:0]  inc;

  logic [31:0] tb2;
  logic [0:0]  act2;
  logic [1:0]  flg2;
  logic        run2;
  logic [47:0] tb3;
  logic [1:0]  act3;
  logic [2:0]  flg3;
  logic        run3;

  always #5 clk = ~clk;

  chess_clock_core dut2 (
    .CLK(clk), .CLR(clr2), .CE(ce), .SELECT(sel), .STOP(stop),
    .Set_Impulse(setp), .SET_BCD(setv), .INC_BCD(inc),
    .time_bcd(tb2), .active(act2), .flag(flg2), .running(run2)
  );

  chess_clock_core #(.PLAYERS(3), .PW(2)) dut3 (
    .CLK(clk), .CLR(clr3), .CE(ce), .SELECT(sel), .STOP(stop),
    .Set_Impulse(setp), .SET_BCD(setv), .INC_BCD(inc),
    .time_bcd(tb3), .active(act3), .flag(flg3), .running(run3)
  );

  typedef struct {
    int          due;
    bit          on3;
    logic [47:0] t;
    logic [1:0]  a;
    logic [2:0]  f;
    logic        r;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   cyc = 0;
  int   last_due = 0;
  bit   use3 = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [47:0] got_t;
  logic [1:0]  got_a;
  logic [2:0]  got_f;
  logic        got_r;

  always @(posedge clk) cyc <= cyc + 1;

  // Drives one cycle of inputs just after a rising edge; they are sampled on the next one.
  task applyStimulus(input bit c, input bit s, input bit e, input bit st, input bit sp,
                     input logic [15:0] sv, input logic [7:0] iv);
    @(posedge clk);
    #1;
    clr2 = use3 ? 1'b1 : c;
    clr3 = use3 ? c : 1'b1;
    sel  = s;
    ce   = e;
    stop = st;
    setp = sp;
    setv = sv;
    inc  = iv;
    last_due = cyc + 1;
  endtask

  task checkOutput(input string name, input logic [47:0] t, input logic [1:0] a,
                   input logic [2:0] f, input logic r);
    exp_t x;
    x.due  = last_due;
    x.on3  = use3;
    x.t    = t;
    x.a    = a;
    x.f    = f;
    x.r    = r;
    x.name = name;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_x = sb.pop_front();
      vectors++;
      got_t = mon_x.on3 ? tb3  : {16'h0000, tb2};
      got_a = mon_x.on3 ? act3 : {1'b0, act2};
      got_f = mon_x.on3 ? flg3 : {1'b0, flg2};
      got_r = mon_x.on3 ? run3 : run2;
      if (mon_x.due != cyc || got_t !== mon_x.t || got_a !== mon_x.a ||
          got_f !== mon_x.f || got_r !== mon_x.r) begin
        miscompares++;
        $display("[TB] FAIL %s: got time=%h active=%0d flag=%b running=%b, expected time=%h active=%0d flag=%b running=%b (due %0d, now %0d)",
                 mon_x.name, got_t, got_a, got_f, got_r,
                 mon_x.t, mon_x.a, mon_x.f, mon_x.r, mon_x.due, cyc);
      end
    end
  end

  initial begin
    clr2 = 1'b1; clr3 = 1'b1;
    sel = 1'b0; ce = 1'b0; stop = 1'b0; setp = 1'b0;
    setv = 16'h0000; inc = 8'h00;
    repeat (2) @(posedge clk);

    $display("[TB] two-player instance");
    use3 = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 8'h00); checkOutput("reset2",       32'h0500_0500, 0, 3'b000, 0);
    applyStimulus(0, 1, 0, 0, 0, 16'h0000, 8'h00); checkOutput("idle_edge",    32'h0500_0500, 0, 3'b000, 1);
    applyStimulus(0, 0, 1, 0, 0, 16'h0000, 8'h00); checkOutput("ce1",          32'h0500_0459, 0, 3'b000, 1);
    applyStimulus(0, 0, 1, 0, 0, 16'h0000, 8'h00); checkOutput("ce2",          32'h0500_0458, 0, 3'b000, 1);
    applyStimulus(0, 0, 1, 0, 0, 16'h0000, 8'h00); checkOutput("ce3",          32'h0500_0457, 0, 3'b000, 1);
    applyStimulus(0, 1, 0, 0, 0, 16'h0000, 8'h05); checkOutput("inc_pass",     32'h0500_0502, 1, 3'b000, 1);
    applyStimulus(0, 0, 1, 1, 0, 16'h0000, 8'h05); checkOutput("stop_ce",      32'h0500_0502, 1, 3'b000, 0);
    applyStimulus(0, 0, 0, 1, 1, 16'h0100, 8'h05); checkOutput("pause_set",    32'h0100_0100, 0, 3'b000, 0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0100, 8'h05); checkOutput("idle_hold",    32'h0100_0100, 0, 3'b000, 0);
    applyStimulus(0, 1, 0, 0, 0, 16'h0100, 8'h05); checkOutput("run_again",    32'h0100_0100, 0, 3'b000, 1);
    applyStimulus(0, 0, 1, 0, 0, 16'h0100, 8'h05); checkOutput("ce_borrow",    32'h0100_0059, 0, 3'b000, 1);
    applyStimulus(0, 0, 0, 1, 0, 16'h0100, 8'h05); checkOutput("pause2",       32'h0100_0059, 0, 3'b000, 0);
    applyStimulus(0, 0, 0, 1, 1, 16'h0002, 8'h05); checkOutput("set0002",      32'h0002_0002, 0, 3'b000, 0);
    applyStimulus(0, 1, 0, 0, 0, 16'h0002, 8'h05); checkOutput("run0002",      32'h0002_0002, 0, 3'b000, 1);
    applyStimulus(0, 0, 1, 0, 0, 16'h0002, 8'h05); checkOutput("ce_0001",      32'h0002_0001, 0, 3'b000, 1);
    applyStimulus(0, 0, 1, 0, 0, 16'h0002, 8'h05); checkOutput("ce_flag",      32'h0002_0000, 0, 3'b001, 0);
    applyStimulus(0, 1, 1, 0, 0, 16'h0002, 8'h05); checkOutput("flag_ce_sel",  32'h0002_0000, 0, 3'b001, 0);
    applyStimulus(0, 0, 1, 1, 0, 16'h0002, 8'h05); checkOutput("flag_ce_stop", 32'h0002_0000, 0, 3'b001, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'h0002, 8'h05); checkOutput("flag_reload",  32'h0002_0002, 0, 3'b000, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'h0000, 8'h05); checkOutput("set0000",      32'h0000_0000, 0, 3'b000, 0);
    applyStimulus(0, 1, 0, 0, 0, 16'h0000, 8'h05); checkOutput("run0000",      32'h0000_0000, 0, 3'b000, 1);
    applyStimulus(0, 0, 1, 0, 0, 16'h0000, 8'h05); checkOutput("zero_flag",    32'h0000_0000, 0, 3'b001, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'h0100, 8'h05); checkOutput("reload0100",   32'h0100_0100, 0, 3'b000, 0);
    applyStimulus(0, 1, 0, 0, 0, 16'h0100, 8'h05); checkOutput("run0100",      32'h0100_0100, 0, 3'b000, 1);
    applyStimulus(0, 0, 1, 0, 0, 16'h0100, 8'h05); checkOutput("ce0100",       32'h0100_0059, 0, 3'b000, 1);
    applyStimulus(1, 1, 1, 0, 1, 16'h0100, 8'h05); checkOutput("midrun_clr",   32'h0500_0500, 0, 3'b000, 0);

    $display("[TB] three-player instance");
    use3 = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 16'h0000, 8'h05); checkOutput("reset3",       48'h0500_0500_0500, 0, 3'b000, 0);
    applyStimulus(0, 1, 0, 0, 0, 16'h0000, 8'h05); checkOutput("idle_edge3",   48'h0500_0500_0500, 0, 3'b000, 1);
    applyStimulus(0, 0, 1, 0, 0, 16'h0000, 8'h05); checkOutput("ce3p",         48'h0500_0500_0459, 0, 3'b000, 1);
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 8'h05); checkOutput("ce_and_edge",  48'h0500_0500_0503, 1, 3'b000, 1);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 8'h05); checkOutput("hold3",        48'h0500_0500_0503, 1, 3'b000, 1);
    applyStimulus(0, 1, 0, 1, 0, 16'h0000, 8'h05); checkOutput("stop_edge",    48'h0500_0500_0503, 1, 3'b000, 0);
    applyStimulus(0, 0, 0, 1, 1, 16'h9958, 8'h05); checkOutput("set9958",      48'h9958_9958_9958, 0, 3'b000, 0);
    applyStimulus(0, 1, 0, 0, 0, 16'h9958, 8'h05); checkOutput("run9958",      48'h9958_9958_9958, 0, 3'b000, 1);
    applyStimulus(0, 0, 0, 0, 0, 16'h9958, 8'h05); checkOutput("hold_a",       48'h9958_9958_9958, 0, 3'b000, 1);
    applyStimulus(0, 1, 0, 0, 0, 16'h9958, 8'h05); checkOutput("pass0_sat",    48'h9958_9958_9959, 1, 3'b000, 1);
    applyStimulus(0, 0, 0, 0, 0, 16'h9958, 8'h05); checkOutput("hold_b",       48'h9958_9958_9959, 1, 3'b000, 1);
    applyStimulus(0, 1, 0, 0, 0, 16'h9958, 8'h05); checkOutput("pass1_sat",    48'h9958_9959_9959, 2, 3'b000, 1);
    applyStimulus(0, 0, 0, 0, 0, 16'h9958, 8'h05); checkOutput("hold_c",       48'h9958_9959_9959, 2, 3'b000, 1);
    applyStimulus(0, 1, 0, 0, 0, 16'h9958, 8'h05); checkOutput("pass2_wrap",   48'h9959_9959_9959, 0, 3'b000, 1);
    applyStimulus(0, 0, 0, 1, 0, 16'h9958, 8'h05); checkOutput("pause3",       48'h9959_9959_9959, 0, 3'b000, 0);
    applyStimulus(0, 0, 0, 1, 1, 16'h0001, 8'h05); checkOutput("set0001",      48'h0001_0001_0001, 0, 3'b000, 0);
    applyStimulus(0, 1, 0, 0, 0, 16'h0001, 8'h05); checkOutput("run0001",      48'h0001_0001_0001, 0, 3'b000, 1);
    applyStimulus(0, 0, 0, 0, 0, 16'h0001, 8'h05); checkOutput("hold_d",       48'h0001_0001_0001, 0, 3'b000, 1);
    applyStimulus(0, 1, 1, 0, 0, 16'h0001, 8'h05); checkOutput("ce_edge_flag", 48'h0001_0001_0000, 0, 3'b001, 0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0001, 8'h05);

    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("[TB] FAIL drain: %0d expected responses never compared, required 0", sb.size());
      vectors     += sb.size();
      miscompares += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
